sigmoid_tanh_pipe: RTL and testbench
====================================

SIGMOID_TANH_PIPE -- requirements
Module: sigmoid_tanh_pipe

Interface
REQ-001 SHALL have parameter W, default 8, meaning input sample width, signed two's complement, range 6..16.
REQ-002 SHALL have parameter F, default 4, meaning input fractional bits, with 2 <= F <= W-3.
REQ-003 SHALL have parameter OF, default 8, meaning output fractional bits, with OF <= 2F.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port x, input, W bits: signed sample, Q(W-F).F.
REQ-008 SHALL have port mode, input, 1 bit: function select, 0 = sigmoid, 1 = tanh; sampled with x.
REQ-009 SHALL have port in_valid, input, 1 bit: x and mode are valid this cycle.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts a sample this cycle.
REQ-011 SHALL have port y, output, OF+2 bits: signed result, Q1.OF.
REQ-012 SHALL have port out_valid, output, 1 bit: y is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts y this cycle.

Function
REQ-014 SHALL be a 3-stage pipeline (S1 abs/offset, S2 square, S3 combine/scale); each stage holds a valid bit, mode and sign; latency is exactly 3 cycles from acceptance to out_valid when never stalled.
REQ-015 SHALL accept a sample on a cycle where in_valid && in_ready; y transfers on a cycle where out_valid && out_ready.
REQ-016 SHALL define advance = !out_valid || out_ready; all stages load together when advance = 1 and all hold when advance = 0; in_ready = advance (combinational).
REQ-017 SHALL sustain one sample per cycle with out_ready held high; no sample is dropped or duplicated under any out_ready pattern.
REQ-018 SHALL compute in S1: a = |x|, with x = -2^(W-1) mapped to 2^(W-1)-1; t = a>>2 for sigmoid, a>>1 for tanh; sat = (t >= 2^F); d = sat ? 0 : 2^F - t (unsigned, F+1 bits).
REQ-019 SHALL compute in S2: sq = d*d, unsigned 2F+2 bits, exact; no truncation.
REQ-020 SHALL compute in S3 for sigmoid: r = 2^(2F) - (sq>>1) if x >= 0, else r = sq>>1.
REQ-021 SHALL compute in S3 for tanh: r = 2^(2F) - sq if x >= 0, else r = sq - 2^(2F).
REQ-022 SHALL form y = r >>> (2F-OF), arithmetic shift with truncation toward minus infinity.
REQ-023 SHALL treat x = 0 as non-negative.
REQ-024 SHALL keep y within [0, 2^OF] for sigmoid and [-2^OF, 2^OF] for tanh for every x; no overflow.
REQ-025 SHALL carry mode per sample through the pipeline; samples of different modes may be interleaved back-to-back.
REQ-026 SHALL hold y and out_valid stable while out_valid && !out_ready.

Reset
REQ-027 SHALL, while rst = 1, clear all stage valid bits and force out_valid = 0 and y = 0, asynchronously; in_ready = 1 as a consequence.
REQ-028 SHALL discard in-flight samples on reset asserted mid-operation; the first out_valid after release corresponds to the first sample accepted after release.
REQ-029 SHALL not accept a sample in any cycle where rst = 1.

Verification (W=8, F=4, OF=8)
REQ-030 SHALL cover sigmoid points: x = 0, 32, -32, 64, -128, 127 -> y = 128, 224, 32, 256, 0, 256, each 3 cycles after acceptance.
REQ-031 SHALL cover tanh points: x = 0, 16, -16, 32, -128 -> y = 0, 192, -192, 256, -256.
REQ-032 SHALL cover streaming: 256 consecutive x = -128..127 with alternating mode and out_ready = 1; outputs match the REQ-018..022 model in order at 1 per cycle.
REQ-033 SHALL cover backpressure: random out_ready with 50% duty while in_valid = 1 continuously; in_ready == advance every cycle, y is stable while stalled, and order/count is preserved.
REQ-034 SHALL cover mid-stream reset: assert rst with 3 samples in flight; out_valid = 0 immediately (asynchronously); after release x = 32 (sigmoid) -> first output is y = 224.
REQ-035 SHALL cover parameter sweep: W=12, F=6, OF=10, x = 0 -> y = 512 (sigmoid) and 0 (tanh).

Source files
------------

// File: rtl/sigmoid_tanh_pipe.sv
// -----------------------------------------------------------------------------
// sigmoid_tanh_pipe
//
// Three-stage fixed-point approximation of sigmoid(x) or tanh(x), chosen per
// sample by `mode`. Both functions share one piecewise-quadratic core:
//
//   S1  a = |x| (most-negative input clamps to the largest positive value)
//       t = a/4 (sigmoid) or a/2 (tanh)
//       d = 1 - t, clamped to 0 once t reaches 1.0          (UQ1.F)
//   S2  sq = d*d, exact                                     (UQ2.2F)
//   S3  sigmoid: r = 1 - sq/2  (x >= 0)   or  sq/2          (x < 0)
//       tanh:    r = 1 - sq    (x >= 0)   or  sq - 1        (x < 0)
//       y = r >>> (2F-OF), floor rounding                   (Q1.OF)
//
// Parameters
//   W   input width, signed two's complement (6..16)
//   F   input fractional bits (2 <= F <= W-3)
//   OF  output fractional bits (OF <= 2F)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   x          input sample, Q(W-F).F
//   mode       0 = sigmoid, 1 = tanh; travels with its sample
//   in_valid   x/mode valid this cycle
//   in_ready   block accepts a sample this cycle
//   y          result, Q1.OF, OF+2 bits signed
//   out_valid  y is valid
//   out_ready  downstream accepts y this cycle
//
// Handshake: a sample is taken on a cycle with in_valid && in_ready, and a
// result leaves on a cycle with out_valid && out_ready. The whole pipeline
// moves as one unit: advance = !out_valid || out_ready. When advance is high
// every stage loads from its predecessor; when low every stage holds, so y and
// out_valid stay stable under backpressure. in_ready is advance itself
// (combinational from out_ready), which keeps full throughput with no skid.
// -----------------------------------------------------------------------------
module sigmoid_tanh_pipe #(
  parameter int W  = 8,
  parameter int F  = 4,
  parameter int OF = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  x,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OF+1:0] y,
  output logic          out_valid,
  input  logic          out_ready
);

  // Width of |x| once the sign bit is gone.
  localparam int AW = W - 1;
  // Width of d = 1 - t, which spans 0..2^F inclusive.
  localparam int DW = F + 1;
  // Width of the exact square and of the signed combine result.
  localparam int SW = 2 * F + 2;
  // Alignment shift from the 2F-fraction combine result to the OF-fraction y.
  localparam int SH = 2 * F - OF;

  localparam logic [W-1:0]         X_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [AW-1:0]        A_MAX = {AW{1'b1}};
  localparam logic [AW-1:0]        T_ONE = AW'(1) << F;
  localparam logic [DW-1:0]        D_ONE = DW'(1) << F;
  localparam logic signed [SW-1:0] R_ONE = SW'(1) << (2 * F);

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic          v1_q, v1_d;
  logic          m1_q, m1_d;
  logic          s1_q, s1_d;
  logic [DW-1:0] d1_q, d1_d;

  logic          v2_q, v2_d;
  logic          m2_q, m2_d;
  logic          s2_q, s2_d;
  logic [SW-1:0] sq2_q, sq2_d;

  logic          v3_q, v3_d;
  logic [OF+1:0] y3_q, y3_d;

  logic advance;

  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign y         = y3_q;

  // ---------------------------------------------------------------------------
  // S1 datapath: magnitude, scale by mode, distance from the knee at t = 1.0
  // ---------------------------------------------------------------------------
  logic [AW-1:0] a_s1;
  logic [AW-1:0] t_s1;
  logic          sat_s1;
  logic [DW-1:0] d_s1;

  always_comb begin
    a_s1 = '0;
    if (!x[W-1]) begin
      a_s1 = x[AW-1:0];
    end else if (x == X_MIN) begin
      // -2^(W-1) has no positive twin; clamp so the magnitude fits in AW bits.
      a_s1 = A_MAX;
    end else begin
      a_s1 = AW'(-x);
    end

    t_s1   = mode ? (a_s1 >> 1) : (a_s1 >> 2);
    sat_s1 = (t_s1 >= T_ONE);
    // t < 2^F whenever not saturated, so its low DW bits carry the full value.
    d_s1   = sat_s1 ? '0 : (D_ONE - t_s1[DW-1:0]);
  end

  // ---------------------------------------------------------------------------
  // S2 datapath: exact square, d <= 2^F so sq <= 2^(2F)
  // ---------------------------------------------------------------------------
  logic [SW-1:0] sq_s2;

  always_comb begin
    sq_s2 = SW'(d1_q) * SW'(d1_q);
  end

  // ---------------------------------------------------------------------------
  // S3 datapath: fold by sign, rescale to OF fraction bits
  // ---------------------------------------------------------------------------
  logic signed [SW-1:0] sq_sgn_s3;
  logic signed [SW-1:0] half_s3;
  logic signed [SW-1:0] r_s3;
  logic [OF+1:0]        y_s3;

  always_comb begin
    // sq never exceeds 2^(2F), so its top bit is clear and it reads as positive.
    sq_sgn_s3 = $signed(sq2_q);
    half_s3   = sq_sgn_s3 >>> 1;
    r_s3      = '0;
    if (!m2_q) begin
      r_s3 = s2_q ? half_s3 : (R_ONE - half_s3);
    end else begin
      r_s3 = s2_q ? (sq_sgn_s3 - R_ONE) : (R_ONE - sq_sgn_s3);
    end
    // |r| <= 2^(2F), so after the shift |y| <= 2^OF and OF+2 bits suffice.
    y_s3 = (OF+2)'(r_s3 >>> SH);
  end

  // ---------------------------------------------------------------------------
  // Next-state: all stages load together on advance, otherwise hold
  // ---------------------------------------------------------------------------
  always_comb begin
    v1_d  = v1_q;
    m1_d  = m1_q;
    s1_d  = s1_q;
    d1_d  = d1_q;
    v2_d  = v2_q;
    m2_d  = m2_q;
    s2_d  = s2_q;
    sq2_d = sq2_q;
    v3_d  = v3_q;
    y3_d  = y3_q;
    if (advance) begin
      v1_d  = in_valid;
      m1_d  = mode;
      s1_d  = x[W-1];   // zero counts as non-negative
      d1_d  = d_s1;
      v2_d  = v1_q;
      m2_d  = m1_q;
      s2_d  = s1_q;
      sq2_d = sq_s2;
      v3_d  = v2_q;
      y3_d  = y_s3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      m1_q  <= 1'b0;
      s1_q  <= 1'b0;
      d1_q  <= '0;
      v2_q  <= 1'b0;
      m2_q  <= 1'b0;
      s2_q  <= 1'b0;
      sq2_q <= '0;
      v3_q  <= 1'b0;
      y3_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      m1_q  <= m1_d;
      s1_q  <= s1_d;
      d1_q  <= d1_d;
      v2_q  <= v2_d;
      m2_q  <= m2_d;
      s2_q  <= s2_d;
      sq2_q <= sq2_d;
      v3_q  <= v3_d;
      y3_q  <= y3_d;
    end
  end

endmodule

// File: tb/tb_sigmoid_tanh_pipe.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_tanh_pipe
//
// Directed bench for sigmoid_tanh_pipe. Default instance (W=8, F=4, OF=8) plus
// a second instance (W=12, F=6, OF=10) for the wide-parameter points. Inputs
// are driven on the falling edge and outputs sampled 1 ns later, well away
// from the rising edge. Every accepted sample pushes a reference result into
// exp_q; every transferred result pops and compares.
// -----------------------------------------------------------------------------
module tb_sigmoid_tanh_pipe;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic [7:0] x;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] y;
  logic       out_valid;
  logic       out_ready;

  sigmoid_tanh_pipe #(.W(8), .F(4), .OF(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Wide instance
  logic [11:0] x2;
  logic        mode2;
  logic        in_valid2;
  logic        in_ready2;
  logic [11:0] y2;
  logic        out_valid2;

  sigmoid_tanh_pipe #(.W(12), .F(6), .OF(10)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .x         (x2),
    .mode      (mode2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .y         (y2),
    .out_valid (out_valid2),
    .out_ready (1'b1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_q[$];

  logic       obs_valid;
  logic       obs_ready;
  logic [9:0] obs_y;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_y     = '0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference model written directly from the function definition.
  function automatic int model(input int xv, input bit md, input int w,
                               input int f, input int of);
    int a, t, d, sq, one, r;
    if (xv < 0) a = (xv == -(1 << (w - 1))) ? (1 << (w - 1)) - 1 : -xv;
    else        a = xv;
    t   = md ? (a >>> 1) : (a >>> 2);
    d   = (t >= (1 << f)) ? 0 : (1 << f) - t;
    sq  = d * d;
    one = 1 << (2 * f);
    if (!md) r = (xv >= 0) ? one - (sq >>> 1) : (sq >>> 1);
    else     r = (xv >= 0) ? one - sq : sq - one;
    return r >>> (2 * f - of);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle on the default instance
  // ---------------------------------------------------------------------------
  task automatic step(input logic iv, input int xv, input logic md, input logic ordy);
    int         m;
    logic [9:0] e;
    @(negedge clk);
    in_valid  = iv;
    x         = xv[7:0];
    mode      = md;
    out_ready = ordy;
    #1;
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_y     = y;
    check("in_ready_eq_advance", obs_ready, !obs_valid || out_ready);
    if (prev_stall) begin
      check("stall_valid_held", obs_valid, 1);
      check("stall_y_held", $signed(obs_y), $signed(prev_y));
    end
    if (obs_valid && out_ready) begin
      check("out_has_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream_y", $signed(obs_y), $signed(e));
      end
    end
    if (in_valid && obs_ready && !rst) begin
      m = model(xv, md, 8, 4, 8);
      e = m[9:0];
      exp_q.push_back(e);
    end
    prev_stall = obs_valid && !out_ready;
    prev_y     = obs_y;
    @(posedge clk);
  endtask

  // One isolated sample with exact latency and hand-computed result.
  task automatic point(input int xv, input logic md, input int exp_y, input string tag);
    step(1'b1, xv, md, 1'b1);
    check({tag, "_accept"}, obs_ready, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    check({tag, "_lat1"}, obs_valid, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    check({tag, "_lat2"}, obs_valid, 0);
    step(1'b0, 0, 1'b0, 1'b1);
    check({tag, "_lat3"}, obs_valid, 1);
    check({tag, "_y"}, $signed(obs_y), exp_y);
  endtask

  task automatic point2(input int xv, input logic md, input int exp_y, input string tag);
    @(negedge clk);
    in_valid2 = 1'b1;
    x2        = xv[11:0];
    mode2     = md;
    #1;
    check({tag, "_accept"}, in_ready2, 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid2 = 1'b0;
      #1;
      if (k < 3) check({tag, "_early"}, out_valid2, 0);
    end
    check({tag, "_valid"}, out_valid2, 1);
    check({tag, "_y"}, $signed(y2), exp_y);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid2 = 1'b0;
    x2        = '0;
    mode2     = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_y", $signed(y), 0);
    check("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sigmoid points
    point(0,    1'b0, 128, "sig_x0");
    point(32,   1'b0, 224, "sig_x32");
    point(-32,  1'b0, 32,  "sig_xm32");
    point(64,   1'b0, 256, "sig_x64");
    point(-128, 1'b0, 0,   "sig_xm128");
    point(127,  1'b0, 256, "sig_x127");

    // Tanh points
    point(0,    1'b1, 0,    "tanh_x0");
    point(16,   1'b1, 192,  "tanh_x16");
    point(-16,  1'b1, -192, "tanh_xm16");
    point(32,   1'b1, 256,  "tanh_x32");
    point(-128, 1'b1, -256, "tanh_xm128");

    // Full-rate sweep of every input, alternating mode
    for (int i = 0; i < 256; i++) begin
      step(1'b1, i - 128, i[0], 1'b1);
      if (i >= 3) check("stream_rate", obs_valid, 1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0, 1'b1);
    check("stream_drained", exp_q.size(), 0);

    // Random backpressure with continuous input
    for (int i = 0; i < 300; i++) begin
      step(1'b1, int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 12; i++) step(1'b0, 0, 1'b0, 1'b1);
    check("bp_drained", exp_q.size(), 0);
    check("bp_idle", obs_valid, 0);

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) step(1'b1, 16 * i, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    check("mr_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mr_async_valid", out_valid, 0);
    check("mr_async_y", $signed(y), 0);
    check("mr_in_ready", in_ready, 1);
    exp_q.delete();
    prev_stall = 1'b0;
    in_valid   = 1'b1;
    x          = 8'hE0;
    @(posedge clk);
    #1;
    check("mr_no_accept", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    point(32, 1'b0, 224, "mr_first");
    check("mr_clean", exp_q.size(), 0);

    // Wide parameter set
    point2(0,     1'b0, 512, "w12_sig_x0");
    point2(0,     1'b1, 0,   "w12_tanh_x0");
    point2(-2048, 1'b0, 0,   "w12_sig_min");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
